// File: rtl/param_reg_file.sv
// param_reg_file: DEPTH x WIDTH register file with function-select writes,
// two combinational read ports, sticky overflow flag and clear-all sweeper.
module param_reg_file #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter bit SAT    = 1'b0,
  parameter bit BYPASS = 1'b0,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [1:0]       FunSel,
  input  logic [DEPTH-1:0] RegSel,
  input  logic [WIDTH-1:0] I,
  input  logic [AW-1:0]    O1Sel,
  input  logic [AW-1:0]    O2Sel,
  input  logic             ClrAll,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic             Busy,
  output logic             OvfFlag
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [AW-1:0]    LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] wr_val [DEPTH];
  logic [DEPTH-1:0] wr_ovf;
  logic [DEPTH-1:0] wr_en;

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] idx_d;
  logic          ovf_q;
  logic          ovf_d;

  logic idle;
  logic fs_clr;
  logic fs_ld;
  logic fs_dec;
  logic fs_inc;

  assign idle   = (state_q == ST_IDLE);
  assign wr_en  = idle ? ~RegSel : '0;

  assign fs_clr = (FunSel == 2'b00);
  assign fs_ld  = (FunSel == 2'b01);
  assign fs_dec = (FunSel == 2'b10);
  assign fs_inc = (FunSel == 2'b11);

  // Per-register result of the selected function, from its own old value.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      wr_val[k] = regs_q[k];
      wr_ovf[k] = 1'b0;
      unique case (1'b1)
        fs_clr: wr_val[k] = '0;
        fs_ld:  wr_val[k] = I;
        fs_dec: begin
          if (regs_q[k] == '0) begin
            wr_ovf[k] = 1'b1;
            wr_val[k] = SAT ? '0 : ONES;
          end else begin
            wr_val[k] = regs_q[k] - WIDTH'(1);
          end
        end
        fs_inc: begin
          if (regs_q[k] == ONES) begin
            wr_ovf[k] = 1'b1;
            wr_val[k] = SAT ? ONES : '0;
          end else begin
            wr_val[k] = regs_q[k] + WIDTH'(1);
          end
        end
      endcase
    end
  end

  // Next register contents: writes in IDLE, one clear per cycle in SWEEP.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      regs_d[k] = regs_q[k];
      if (wr_en[k]) begin
        regs_d[k] = wr_val[k];
      end
      if (!idle && (idx_q == AW'(k))) begin
        regs_d[k] = '0;
      end
    end
  end

  // Sweep controller: ClrAll only starts a sweep from IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ClrAll) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (idx_q == LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
    endcase
  end

  // Sticky overflow: a new overflow beats a simultaneous clear.
  always_comb begin
    ovf_d = (|(wr_ovf & wr_en)) | (ovf_q & ~FlagClr);
  end

  // Read port 1: out-of-range select reads zero.
  always_comb begin
    O1 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (O1Sel == AW'(k)) begin
        O1 = (BYPASS && wr_en[k]) ? wr_val[k] : regs_q[k];
      end
    end
  end

  // Read port 2: out-of-range select reads zero.
  always_comb begin
    O2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (O2Sel == AW'(k)) begin
        O2 = (BYPASS && wr_en[k]) ? wr_val[k] : regs_q[k];
      end
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy    = (state_q == ST_SWEEP);
  assign OvfFlag = ovf_q;

endmodule

// File: tb/tb_param_reg_file.sv
// tb_param_reg_file: three configurations of param_reg_file driven in
// lockstep against a behavioural model through an expected-value queue.
module tb_param_reg_file;

  typedef struct packed {
    logic [1:0] fs;
    logic [7:0] rs;
    logic [7:0] d;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       clr;
    logic       fc;
    logic       tk;
  } step_t;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] FunSel;
  logic [7:0] RegSel;
  logic [7:0] I;
  logic [2:0] O1Sel;
  logic [2:0] O2Sel;
  logic       ClrAll;
  logic       FlagClr;

  logic [7:0] o1 [3];
  logic [7:0] o2 [3];
  logic       busy [3];
  logic       ovf [3];

  int ntests = 0;
  int nfail  = 0;

  logic [17:0] sb [$];

  logic [7:0] mr [3][8];
  logic       mst [3];
  logic [2:0] midx [3];
  logic       mov [3];

  always #5 CLK = ~CLK;

  param_reg_file #(.WIDTH(8), .DEPTH(8), .SAT(1'b0), .BYPASS(1'b0)) u_a (
    .CLK(CLK), .RST_N(RST_N), .FunSel(FunSel), .RegSel(RegSel), .I(I),
    .O1Sel(O1Sel), .O2Sel(O2Sel), .ClrAll(ClrAll), .FlagClr(FlagClr),
    .O1(o1[0]), .O2(o2[0]), .Busy(busy[0]), .OvfFlag(ovf[0])
  );

  param_reg_file #(.WIDTH(8), .DEPTH(8), .SAT(1'b1), .BYPASS(1'b1)) u_b (
    .CLK(CLK), .RST_N(RST_N), .FunSel(FunSel), .RegSel(RegSel), .I(I),
    .O1Sel(O1Sel), .O2Sel(O2Sel), .ClrAll(ClrAll), .FlagClr(FlagClr),
    .O1(o1[1]), .O2(o2[1]), .Busy(busy[1]), .OvfFlag(ovf[1])
  );

  param_reg_file #(.WIDTH(8), .DEPTH(5), .SAT(1'b0), .BYPASS(1'b0)) u_c (
    .CLK(CLK), .RST_N(RST_N), .FunSel(FunSel), .RegSel(RegSel[4:0]), .I(I),
    .O1Sel(O1Sel), .O2Sel(O2Sel), .ClrAll(ClrAll), .FlagClr(FlagClr),
    .O1(o1[2]), .O2(o2[2]), .Busy(busy[2]), .OvfFlag(ovf[2])
  );

  function automatic int dep_of(input int n);
    return (n == 2) ? 5 : 8;
  endfunction

  function automatic bit sat_of(input int n);
    return (n == 1);
  endfunction

  function automatic bit byp_of(input int n);
    return (n == 1);
  endfunction

  function automatic step_t mk(input logic [1:0] fs, input logic [7:0] rs,
                               input logic [7:0] d, input int s1, input int s2,
                               input logic clr, input logic fc, input logic tk);
    step_t s;
    s.fs  = fs;
    s.rs  = rs;
    s.d   = d;
    s.s1  = 3'(s1);
    s.s2  = 3'(s2);
    s.clr = clr;
    s.fc  = fc;
    s.tk  = tk;
    return s;
  endfunction

  function automatic logic [8:0] apply(input logic [1:0] fs, input logic [7:0] v,
                                       input logic [7:0] d, input bit s);
    case (fs)
      2'b00: return 9'h000;
      2'b01: return {1'b0, d};
      2'b10: begin
        if (v == 8'h00) return {1'b1, (s ? 8'h00 : 8'hFF)};
        return {1'b0, 8'(v - 8'h01)};
      end
      default: begin
        if (v == 8'hFF) return {1'b1, (s ? 8'hFF : 8'h00)};
        return {1'b0, 8'(v + 8'h01)};
      end
    endcase
  endfunction

  function automatic logic [7:0] exp_rd(input int n, input logic [2:0] sel);
    logic [8:0] r;
    if (int'(sel) >= dep_of(n)) return 8'h00;
    if (byp_of(n) && !mst[n] && !RegSel[sel]) begin
      r = apply(FunSel, mr[n][sel], I, sat_of(n));
      return r[7:0];
    end
    return mr[n][sel];
  endfunction

  function automatic logic [17:0] obs(input int n);
    return {o1[n], o2[n], busy[n], ovf[n]};
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 8; k++) mr[n][k] = 8'h00;
      mst[n]  = 1'b0;
      midx[n] = 3'd0;
      mov[n]  = 1'b0;
    end
  endtask

  task automatic model_tick();
    logic [8:0] r;
    logic       set;
    for (int n = 0; n < 3; n++) begin
      if (!mst[n]) begin
        set = 1'b0;
        for (int k = 0; k < dep_of(n); k++) begin
          if (!RegSel[k]) begin
            r = apply(FunSel, mr[n][k], I, sat_of(n));
            mr[n][k] = r[7:0];
            set = set | r[8];
          end
        end
        mov[n] = set | (mov[n] & ~FlagClr);
        if (ClrAll) begin
          mst[n]  = 1'b1;
          midx[n] = 3'd0;
        end
      end else begin
        mov[n] = mov[n] & ~FlagClr;
        mr[n][midx[n]] = 8'h00;
        if (int'(midx[n]) == dep_of(n) - 1) begin
          mst[n]  = 1'b0;
          midx[n] = 3'd0;
        end else begin
          midx[n] = midx[n] + 3'd1;
        end
      end
    end
  endtask

  task automatic drive(input step_t s);
    FunSel  = s.fs;
    RegSel  = s.rs;
    I       = s.d;
    O1Sel   = s.s1;
    O2Sel   = s.s2;
    ClrAll  = s.clr;
    FlagClr = s.fc;
    #1;
    for (int n = 0; n < 3; n++) begin
      sb.push_back({exp_rd(n, s.s1), exp_rd(n, s.s2), mst[n], mov[n]});
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_tick();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [17:0] want;
    logic [17:0] got;
    drive(mk(2'b01, 8'hFF, 8'h00, 3, 7, 1'b0, 1'b0, 1'b0));
    for (int n = 0; n < 3; n++) begin
      want = sb.pop_front();
      got  = obs(n);
      ntests++;
      if (got !== want) begin
        nfail++;
        $display("FAIL reset u%0d got %h want %h", n, got, want);
      end
    end
  endtask

  task automatic test_load();
    logic [17:0] want;
    logic [17:0] got;
    step_t st [$];
    st.push_back(mk(2'b01, 8'b11111011, 8'hA5, 2, 5, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 2, 5, 1'b0, 1'b0, 1'b0));
    st.push_back(mk(2'b01, 8'h00, 8'h10, 0, 7, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b11, 8'b01010101, 8'h00, 1, 3, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 1, 2, 1'b0, 1'b0, 1'b0));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 7, 0, 1'b0, 1'b0, 1'b0));
    foreach (st[j]) begin
      drive(st[j]);
      for (int n = 0; n < 3; n++) begin
        want = sb.pop_front();
        got  = obs(n);
        ntests++;
        if (got !== want) begin
          nfail++;
          $display("FAIL load s%0d u%0d got %h want %h", j, n, got, want);
        end
      end
      if (st[j].tk) tick();
    end
  endtask

  task automatic test_ovf();
    logic [17:0] want;
    logic [17:0] got;
    step_t st [$];
    st.push_back(mk(2'b01, 8'hFC, 8'hFF, 0, 1, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b00, 8'hFD, 8'h00, 0, 1, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b11, 8'hFE, 8'h00, 0, 1, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 0, 1, 1'b0, 1'b1, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 0, 1, 1'b0, 1'b0, 1'b0));
    st.push_back(mk(2'b10, 8'hFD, 8'h00, 1, 0, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 1, 0, 1'b0, 1'b0, 1'b0));
    st.push_back(mk(2'b11, 8'hFE, 8'h00, 0, 1, 1'b0, 1'b1, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 0, 1, 1'b0, 1'b1, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 0, 1, 1'b0, 1'b0, 1'b0));
    foreach (st[j]) begin
      drive(st[j]);
      for (int n = 0; n < 3; n++) begin
        want = sb.pop_front();
        got  = obs(n);
        ntests++;
        if (got !== want) begin
          nfail++;
          $display("FAIL ovf s%0d u%0d got %h want %h", j, n, got, want);
        end
      end
      if (st[j].tk) tick();
    end
  endtask

  task automatic test_bypass();
    logic [17:0] want;
    logic [17:0] got;
    step_t st [$];
    st.push_back(mk(2'b01, 8'hEF, 8'h11, 4, 3, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b01, 8'hEF, 8'h3C, 4, 4, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 4, 3, 1'b0, 1'b0, 1'b0));
    st.push_back(mk(2'b10, 8'hEF, 8'h00, 4, 2, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 4, 2, 1'b0, 1'b0, 1'b0));
    foreach (st[j]) begin
      drive(st[j]);
      for (int n = 0; n < 3; n++) begin
        want = sb.pop_front();
        got  = obs(n);
        ntests++;
        if (got !== want) begin
          nfail++;
          $display("FAIL bypass s%0d u%0d got %h want %h", j, n, got, want);
        end
      end
      if (st[j].tk) tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] want;
    logic [17:0] got;
    step_t st [$];
    st.push_back(mk(2'b01, 8'hF7, 8'hFE, 3, 0, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 3; i++) begin
      st.push_back(mk(2'b11, 8'hF7, 8'h00, 3, 0, 1'b0, 1'b0, 1'b1));
    end
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 3, 0, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 3; i++) begin
      st.push_back(mk(2'b10, 8'hF7, 8'h00, 3, 0, 1'b0, 1'b0, 1'b1));
    end
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 3, 0, 1'b0, 1'b0, 1'b0));
    foreach (st[j]) begin
      drive(st[j]);
      for (int n = 0; n < 3; n++) begin
        want = sb.pop_front();
        got  = obs(n);
        ntests++;
        if (got !== want) begin
          nfail++;
          $display("FAIL b2b s%0d u%0d got %h want %h", j, n, got, want);
        end
      end
      if (st[j].tk) tick();
    end
  endtask

  task automatic test_select_range();
    logic [17:0] want;
    logic [17:0] got;
    step_t st [$];
    st.push_back(mk(2'b01, 8'h00, 8'h5E, 5, 6, 1'b0, 1'b1, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 5, 6, 1'b0, 1'b0, 1'b0));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 7, 4, 1'b0, 1'b0, 1'b0));
    foreach (st[j]) begin
      drive(st[j]);
      for (int n = 0; n < 3; n++) begin
        want = sb.pop_front();
        got  = obs(n);
        ntests++;
        if (got !== want) begin
          nfail++;
          $display("FAIL range s%0d u%0d got %h want %h", j, n, got, want);
        end
      end
      if (st[j].tk) tick();
    end
  endtask

  task automatic test_sweep();
    logic [17:0] want;
    logic [17:0] got;
    logic [7:0]  m;
    step_t st [$];
    for (int k = 0; k < 8; k++) begin
      m = 8'h01 << k;
      st.push_back(mk(2'b01, ~m, 8'(k + 1), k, 0, 1'b0, 1'b0, 1'b1));
    end
    st.push_back(mk(2'b01, 8'h7F, 8'h77, 7, 6, 1'b1, 1'b0, 1'b1));
    for (int j = 0; j < 8; j++) begin
      if (j == 3) begin
        st.push_back(mk(2'b11, 8'hBF, 8'h00, j, 6, 1'b1, 1'b0, 1'b1));
      end else begin
        st.push_back(mk(2'b01, 8'hFF, 8'h00, j, 6, 1'b0, 1'b0, 1'b1));
      end
    end
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 6, 7, 1'b0, 1'b0, 1'b0));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 0, 4, 1'b0, 1'b0, 1'b0));
    foreach (st[j]) begin
      drive(st[j]);
      for (int n = 0; n < 3; n++) begin
        want = sb.pop_front();
        got  = obs(n);
        ntests++;
        if (got !== want) begin
          nfail++;
          $display("FAIL sweep s%0d u%0d got %h want %h", j, n, got, want);
        end
      end
      if (st[j].tk) tick();
    end
  endtask

  task automatic test_reset_sweep();
    logic [17:0] want;
    logic [17:0] got;
    step_t st [$];
    st.push_back(mk(2'b01, 8'h00, 8'h33, 0, 7, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 0, 7, 1'b1, 1'b0, 1'b1));
    for (int j = 0; j < 3; j++) begin
      st.push_back(mk(2'b01, 8'hFF, 8'h00, j, 7, 1'b0, 1'b0, 1'b1));
    end
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 5, 6, 1'b0, 1'b0, 1'b0));
    foreach (st[j]) begin
      drive(st[j]);
      for (int n = 0; n < 3; n++) begin
        want = sb.pop_front();
        got  = obs(n);
        ntests++;
        if (got !== want) begin
          nfail++;
          $display("FAIL rsw_pre s%0d u%0d got %h want %h", j, n, got, want);
        end
      end
      if (st[j].tk) tick();
    end
    RST_N = 1'b0;
    model_reset();
    for (int s = 0; s < 8; s++) begin
      drive(mk(2'b01, 8'hFF, 8'h00, s, 7 - s, 1'b0, 1'b0, 1'b0));
      for (int n = 0; n < 3; n++) begin
        want = sb.pop_front();
        got  = obs(n);
        ntests++;
        if (got !== want) begin
          nfail++;
          $display("FAIL rsw_in s%0d u%0d got %h want %h", s, n, got, want);
        end
      end
    end
    @(negedge CLK);
    RST_N = 1'b1;
    st.delete();
    st.push_back(mk(2'b01, 8'hFB, 8'h5A, 2, 3, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b11, 8'hF7, 8'h00, 2, 3, 1'b0, 1'b0, 1'b1));
    st.push_back(mk(2'b01, 8'hFF, 8'h00, 2, 3, 1'b0, 1'b0, 1'b0));
    foreach (st[j]) begin
      drive(st[j]);
      for (int n = 0; n < 3; n++) begin
        want = sb.pop_front();
        got  = obs(n);
        ntests++;
        if (got !== want) begin
          nfail++;
          $display("FAIL rsw_post s%0d u%0d got %h want %h", j, n, got, want);
        end
      end
      if (st[j].tk) tick();
    end
  endtask

  initial begin
    RST_N   = 1'b0;
    FunSel  = 2'b01;
    RegSel  = 8'hFF;
    I       = 8'h00;
    O1Sel   = 3'd0;
    O2Sel   = 3'd0;
    ClrAll  = 1'b0;
    FlagClr = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    test_reset();
    RST_N = 1'b1;
    @(negedge CLK);
    test_load();
    test_ovf();
    test_bypass();
    test_back_to_back();
    test_select_range();
    test_sweep();
    test_reset_sweep();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d tests", ntests);
    $fatal(1);
  end

endmodule
